// File: rtl/mult_rr_scheduler_pkg.sv
// mult_rr_scheduler_pkg: shared state encoding and default sizing for the multiplier scheduler
package mult_rr_scheduler_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_IDW     = 2;
    localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/mult_rr_scheduler_if.sv
// mult_rr_scheduler_if: requester-side request/grant and tagged response bus
interface mult_rr_scheduler_if
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = DEF_IDW
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_err;
    modport master (output req, req_a, req_b, input gnt, rsp_valid, rsp_id, rsp_product, rsp_err);
    modport slave  (input req, req_a, req_b, output gnt, rsp_valid, rsp_id, rsp_product, rsp_err);
endinterface

// File: rtl/mult_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or after ptr
module rr_pick
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id
);
    // scan from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        gnt = '0;
        id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                gnt = NREQ'(1) << ((int'(ptr) + i) % NREQ);
                id  = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one multiplier round-robin and flags job latency variation
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_rr_scheduler_if.slave   bus,
    output logic                 busy,
    output logic                 lat_leak,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplicand,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_done
);
    localparam int CW = $clog2(TIMEOUT);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, id, pick_id;
    logic [NREQ-1:0] pick_gnt;
    logic [CW-1:0]   cnt, ref_lat;
    logic            ref_valid, done_ok, tmo;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    // a done in the first WAIT cycle (cnt==0) is stale from the previous job
    assign done_ok    = mul_done && cnt != '0;
    assign tmo        = cnt == CW'(TIMEOUT - 1);
    assign bus.rsp_id = id;

    // state register
    always_ff @(posedge clk) state <= !rst ? IDLE : state_nxt;

    // next-state decode plus grant and strobe outputs
    always_comb begin
        state_nxt     = state;
        bus.gnt       = '0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt = ISSUE;
                    bus.gnt   = pick_gnt;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (done_ok || tmo) ? DELIVER : WAIT;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        mul_start     = state == ISSUE;
        bus.rsp_valid = state == DELIVER;
        busy          = state != IDLE;
    end

    // operand capture, latency counting, result capture and pointer rotation
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr              <= '0;
            id               <= '0;
            cnt              <= '0;
            ref_lat          <= '0;
            ref_valid        <= 1'b0;
            lat_leak         <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            bus.rsp_product  <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            if (state == IDLE && |bus.req) begin
                id               <= pick_id;
                mul_multiplier   <= bus.req_a[int'(pick_id)*WIDTH +: WIDTH];
                mul_multiplicand <= bus.req_b[int'(pick_id)*WIDTH +: WIDTH];
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (done_ok) begin
                    bus.rsp_product <= mul_product;
                    bus.rsp_err     <= 1'b0;
                    if (!ref_valid) begin
                        ref_lat   <= cnt;
                        ref_valid <= 1'b1;
                    end else if (cnt != ref_lat) begin
                        lat_leak  <= 1'b1;
                    end
                end else if (tmo) begin
                    bus.rsp_product <= '0;
                    bus.rsp_err     <= 1'b1;
                end
            end
            if (state == DELIVER) ptr <= (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: scoreboard bench with a variable-latency multiplier model
module tb_mult_rr_scheduler;
    import mult_rr_scheduler_pkg::*;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 64;

    typedef struct packed {
        logic [IW-1:0]  id;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           busy, lat_leak, mul_start, mul_done;
    logic [W-1:0]   mul_multiplier, mul_multiplicand;
    logic [2*W-1:0] mul_product, mprod;
    exp_t           sb[$];
    int             errors = 0, checks = 0, cyc_n = 0, rsp_cyc = 0, rsp_seen = 0;
    int             mul_lat = 3, left = 0;

    always #5 clk = ~clk;

    mult_rr_scheduler_if #(.NREQ(N), .WIDTH(W), .IDW(IW)) bus ();

    mult_rr_scheduler #(.WIDTH(W), .NREQ(N), .IDW(IW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .busy             (busy),
        .lat_leak         (lat_leak),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    // free-running cycle counter for latency measurements
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // multiplier model: done pulses mul_lat cycles after start; mul_lat==0 never finishes
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (!rst) left <= 0;
        else if (mul_start) begin
            left  <= mul_lat;
            mprod <= mul_multiplier * mul_multiplicand;
        end else if (left != 0) begin
            left <= left - 1;
            if (left == 1) begin
                mul_done    <= 1'b1;
                mul_product <= mprod;
            end
        end
    end

    // response monitor: pop the scoreboard on every result strobe
    always @(negedge clk) begin
        if (rst && bus.rsp_valid === 1'b1) begin
            exp_t e;
            rsp_cyc = cyc_n;
            rsp_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d with nothing outstanding", bus.rsp_id);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (bus.rsp_id !== e.id) begin
                    errors++;
                    $display("FAIL rsp_id: got %0d want %0d", bus.rsp_id, e.id);
                end
                if (bus.rsp_product !== e.prod) begin
                    errors++;
                    $display("FAIL rsp_product: got %0d want %0d (id %0d)", bus.rsp_product, e.prod, e.id);
                end
                if (bus.rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_err: got %b want %b (id %0d)", bus.rsp_err, e.err, e.id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.req = '0;
        step();
        step();
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.req_a[i*W +: W] = W'(a);
        bus.req_b[i*W +: W] = W'(b);
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int gc, output bit ok);
        ok = 1'b0;
        g  = '0;
        gc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (|bus.gnt) begin
                g  = bus.gnt;
                gc = cyc_n;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) step();
        @(negedge clk);
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        if (lat_leak !== 1'b0) begin errors++; $display("FAIL reset_lat_leak: got %b want 0", lat_leak); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        if (mul_multiplier !== '0) begin errors++; $display("FAIL reset_mul_multiplier: got %0d want 0", mul_multiplier); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        int gc;
        bit ok;
        step();
        set_ops(0, 3, 5);
        bus.req = 4'b0001;
        wait_gnt(g, gc, ok);
        checks += 2;
        if (!ok || g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
        else sb.push_back('{id: 2'd0, prod: 8'd15, err: 1'b0});
        if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", mul_start); end
        step();
        bus.req = '0;
        @(negedge clk);
        checks += 3;
        if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", mul_start); end
        if (mul_multiplier !== 4'd3) begin errors++; $display("FAIL single_op_a: got %0d want 3", mul_multiplier); end
        if (mul_multiplicand !== 4'd5) begin errors++; $display("FAIL single_op_b: got %0d want 5", mul_multiplicand); end
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", mul_start); end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_contention();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] g;
        int gc;
        bit ok;
        apply_reset();
        mul_lat = 3;
        for (int i = 0; i < N; i++) set_ops(i, i + 1, 2);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, gc, ok);
            checks++;
            if (!ok || g !== N'(1 << order[k])) begin
                errors++;
                $display("FAIL contention_gnt%0d: got %b want %b", k, g, N'(1 << order[k]));
            end
            sb.push_back('{id: IW'(order[k]), prod: 8'((order[k] + 1) * 2), err: 1'b0});
        end
        step();
        bus.req = '0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] g;
        int gc;
        bit ok;
        apply_reset();
        set_ops(3, 5, 3);
        set_ops(0, 2, 2);
        bus.req = 4'b1000;
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b want 1000", g); end
        sb.push_back('{id: 2'd3, prod: 8'd15, err: 1'b0});
        step();
        bus.req = '0;
        drain(ok);
        step();
        bus.req = 4'b1001;
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin errors++; $display("FAIL wrap_to0: got %b want 0001", g); end
        sb.push_back('{id: 2'd0, prod: 8'd4, err: 1'b0});
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin errors++; $display("FAIL wrap_to3: got %b want 1000", g); end
        sb.push_back('{id: 2'd3, prod: 8'd15, err: 1'b0});
        step();
        bus.req = '0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        int gc;
        bit ok;
        mul_lat = 0;
        set_ops(1, 7, 7);
        step();
        bus.req = 4'b0010;
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin errors++; $display("FAIL timeout_gnt: got %b want 0010", g); end
        sb.push_back('{id: 2'd1, prod: 8'd0, err: 1'b1});
        step();
        bus.req = '0;
        drain(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL timeout_drain: got %0d pending want 0", sb.size()); end
        if (rsp_cyc - gc !== TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", rsp_cyc - gc, TO + 2); end
        if (lat_leak !== 1'b0) begin errors++; $display("FAIL timeout_leak: got %b want 0", lat_leak); end
        mul_lat = 3;
    endtask

    task automatic test_leak();
        int lats[3] = '{4, 5, 4};
        logic want[3] = '{1'b0, 1'b1, 1'b1};
        logic [N-1:0] g;
        int gc;
        bit ok;
        apply_reset();
        for (int j = 0; j < 3; j++) begin
            mul_lat = lats[j];
            set_ops(2, j + 1, 3);
            step();
            bus.req = 4'b0100;
            wait_gnt(g, gc, ok);
            checks++;
            if (!ok || g !== 4'b0100) begin errors++; $display("FAIL leak_gnt%0d: got %b want 0100", j, g); end
            sb.push_back('{id: 2'd2, prod: 8'((j + 1) * 3), err: 1'b0});
            step();
            bus.req = '0;
            drain(ok);
            checks++;
            if (!ok || lat_leak !== want[j]) begin
                errors++;
                $display("FAIL leak_job%0d: got %b want %b", j, lat_leak, want[j]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] g;
        int gc, seen0;
        bit ok;
        mul_lat = 0;
        set_ops(3, 1, 1);
        step();
        bus.req = 4'b1000;
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin errors++; $display("FAIL midrst_gnt: got %b want 1000", g); end
        step();
        bus.req = '0;
        repeat (4) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb.delete();
        seen0 = rsp_seen;
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (lat_leak !== 1'b0) begin errors++; $display("FAIL midrst_leak: got %b want 0", lat_leak); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b want 0", mul_start); end
        repeat (5) step();
        checks++;
        if (rsp_seen !== seen0) begin errors++; $display("FAIL midrst_no_rsp: got %0d responses want 0", rsp_seen - seen0); end
        mul_lat = 3;
        set_ops(2, 2, 6);
        bus.req = 4'b0100;
        wait_gnt(g, gc, ok);
        checks++;
        if (!ok || g !== 4'b0100) begin errors++; $display("FAIL midrst_regnt: got %b want 0100", g); end
        sb.push_back('{id: 2'd2, prod: 8'd12, err: 1'b0});
        step();
        bus.req = '0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_drain: got %0d pending want 0", sb.size()); end
    endtask

    // watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // test sequence
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_timeout();
        test_leak();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Round-robin scheduler sharing one constant-time multiplier between NREQ requesters.
- Accepts operand pairs over a per-requester req/gnt handshake, issues one job at a time to the multiplier, and returns the product tagged with the requester id.
- Measures the start-to-done latency of every job and raises a sticky flag when any job's latency differs from the first job's. This gives a run-time constant-time check at system level.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must be at least clog2(NREQ).
- TIMEOUT, 64, maximum WAIT cycles before a job is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  request level per requester; operands must be held stable while req is high.
- req_a  in  NREQ*WIDTH  multiplier operand, requester i at slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  multiplicand operand, same slicing as req_a.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester are captured this cycle.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  IDW  requester id of the result.
- rsp_product  out  2*WIDTH  product; zero when rsp_err is 1.
- rsp_err  out  1  job timed out; qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- lat_leak  out  1  sticky: a job latency differed from the reference latency.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_multiplier  out  WIDTH  captured multiplier operand.
- mul_multiplicand  out  WIDTH  captured multiplicand operand.
- mul_product  in  2*WIDTH  multiplier result.
- mul_done  in  1  multiplier productDone.

Behaviour:
- Reset: sampled on the clk edge when rst==0.
  - All outputs go to 0; state goes to IDLE; priority pointer goes to 0.
  - The latency reference is cleared and marked invalid.
  - Reset mid-job abandons the job with no response; mul_start is never asserted in the cycle after reset.
- State machine: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - Pulse gnt for the winner; latch its operands into mul_multiplier/mul_multiplicand; latch its id.
  - Go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle.
  - Clear the latency counter to 0; go to WAIT.
- WAIT:
  - The counter increments by 1 each cycle.
  - mul_done is ignored in the first WAIT cycle, to mask stale done from the previous job.
  - From the second WAIT cycle, mul_done==1 captures mul_product and the counter value, then goes to DELIVER.
  - If the counter reaches TIMEOUT-1 without done: rsp_err=1, product forced to 0, go to DELIVER. A timed-out job does not update or compare latency.
- DELIVER:
  - rsp_valid=1 for one cycle with rsp_id, rsp_product and rsp_err.
  - ptr <= id+1 modulo NREQ; go to IDLE.
- Latency check, on a successful job only:
  - If the reference is invalid, store the captured count and mark it valid.
  - Otherwise, if the count differs from the reference, set lat_leak=1. lat_leak clears only on reset.
- Fixed scheduler overhead: gnt to mul_start is 1 cycle. mul_done capture to rsp_valid is 1 cycle. Back-to-back jobs therefore have gnt spacing of multiplier latency + 4 cycles.
- Fairness: a requester holding req is granted within NREQ jobs.
- Simultaneous events:
  - A requester that drops req in the same cycle as its gnt is still served.
  - req arriving during a job waits for IDLE.
  - A new req seen in the DELIVER cycle is not granted until the following IDLE cycle.
- Operands are captured only at gnt; later changes to req_a/req_b do not affect an in-flight job.

Decomposition:
- Shared package: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3) and the default WIDTH/NREQ/TIMEOUT values.
- One natural sub-module: rr_pick. It is combinational, takes req and ptr, and returns a one-hot grant plus the encoded id; it is reused by other arbiters.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Single request: after reset, req=0001, a=3, b=5 -> gnt[0] pulse; mul_start exactly 1 cycle later; rsp_valid with rsp_id=0, rsp_product=15, rsp_err=0.
- Contention: req=1111 held with a=i+1, b=2 for requester i -> grants in order 0,1,2,3,0; products 2,4,6,8; ptr rotation verified.
- Pointer wrap: req=1001 after serving requester 3 -> next grant is requester 0, then requester 3.
- Timeout: multiplier model never asserts done -> rsp_valid exactly TIMEOUT+2 cycles after gnt, with rsp_err=1 and rsp_product=0; lat_leak stays 0.
- Leak detect: model with done latency 4 on the first job and 5 on the second -> lat_leak=0 after job 1, lat_leak=1 after job 2, still 1 after job 3 at latency 4.
- Reset mid-WAIT: rst=0 for 1 cycle during WAIT -> no rsp_valid; busy=0 and lat_leak=0 next cycle; a new req=0100 is granted to requester 2 with ptr at 0 semantics.
